if_fetch_stage: RTL

- Instruction-fetch front end of the 64-bit RISC-V pipeline; sits directly upstream of the Datapath (decode onward).
- Owns the fetch PC and issues in-order requests to instruction memory, which may respond after a variable latency.
- Buffers returned words with their PCs and hands {Instruction, PCNow, PCNext4} to decode over a valid/ready handshake.
- Honours PCWrite (stall) and Jump/NewPC (redirect, flushing stale fetches).

---
 rtl/riscv_fetch_pkg.sv | 13 +
 rtl/fetch_slot_queue.sv | 69 ++++++
 rtl/if_fetch_stage.sv | 88 ++++++++
 3 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared constants and slot type for the instruction-fetch front end.
package riscv_fetch_pkg;
  localparam int unsigned XLEN = 64;
  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               filled;
  } slot_t;
endpackage

// File: rtl/fetch_slot_queue.sv
// Circular buffer of fetch slots: allocated on request, filled on response, popped by decode.
module fetch_slot_queue
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = AW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               alloc,
  input  logic [XLEN-1:0]    alloc_pc,
  input  logic               fill,
  input  logic [INSTR_W-1:0] fill_instr,
  input  logic               pop,
  output slot_t              head,
  output logic [CW-1:0]      used,
  output logic [CW-1:0]      inflight
);

  slot_t         slots [DEPTH];
  logic [AW-1:0] alloc_ptr;
  logic [AW-1:0] fill_ptr;
  logic [AW-1:0] head_ptr;

  // alloc, fill and pop always target distinct slots, so their writes never collide
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots[i] <= '{pc: '0, instr: NOP_INSTR, filled: 1'b0};
      end
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      used      <= '0;
      inflight  <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots[i].filled <= 1'b0;
      end
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      used      <= '0;
      inflight  <= '0;
    end else begin
      if (pop) begin
        slots[head_ptr].filled <= 1'b0;
        head_ptr <= head_ptr + AW'(1);
      end
      if (alloc) begin
        slots[alloc_ptr].pc     <= alloc_pc;
        slots[alloc_ptr].filled <= 1'b0;
        alloc_ptr <= alloc_ptr + AW'(1);
      end
      if (fill) begin
        slots[fill_ptr].instr  <= fill_instr;
        slots[fill_ptr].filled <= 1'b1;
        fill_ptr <= fill_ptr + AW'(1);
      end
      used     <= used + CW'(alloc) - CW'(pop);
      inflight <= inflight + CW'(alloc) - CW'(fill);
    end
  end

  assign head = slots[head_ptr];

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch front end: owns the fetch PC, issues in-order imem requests and hands words to decode.
module if_fetch_stage
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned XLEN = riscv_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               PCWrite,
  input  logic               Jump,
  input  logic [XLEN-1:0]    NewPC,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] Instruction,
  output logic [XLEN-1:0]    PCNow,
  output logic [XLEN-1:0]    PCNext4
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   used;
  logic [CW-1:0]   inflight;
  slot_t           head;
  logic            room;
  logic            rsp_live;
  logic            alloc;
  logic            fill;
  logic            pop;

  // Only registered counts feed the request decision; a same-cycle pop never frees a slot.
  assign room = (used < CW'(DEPTH)) &&
                (({1'b0, inflight} + {1'b0, drop_cnt}) < (CW + 1)'(DEPTH));

  assign imem_req_valid = PCWrite & ~Jump & ~Reset & room;
  assign imem_req_addr  = fetch_pc;
  assign alloc          = imem_req_valid & imem_req_ready;

  // A response with nothing outstanding or being dropped is spurious and ignored.
  assign rsp_live = imem_rsp_valid & ((inflight != '0) | (drop_cnt != '0));
  assign fill     = rsp_live & ~Jump & (drop_cnt == '0);

  assign if_valid = head.filled & ~Jump & ~Reset;
  assign pop      = if_valid & if_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (Jump) begin
      fetch_pc <= NewPC;
      drop_cnt <= drop_cnt + inflight - CW'(rsp_live);
    end else begin
      if (alloc) fetch_pc <= fetch_pc + XLEN'(4);
      if (rsp_live && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_slot_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (Clk),
    .reset     (Reset),
    .flush     (Jump),
    .alloc     (alloc),
    .alloc_pc  (fetch_pc),
    .fill      (fill),
    .fill_instr(imem_rsp_data),
    .pop       (pop),
    .head      (head),
    .used      (used),
    .inflight  (inflight)
  );

  assign Instruction = head.instr;
  assign PCNow       = head.pc;
  assign PCNext4     = head.pc + XLEN'(4);

endmodule
